// File: rtl/fft_sample_bank.sv
// 4-entry complex sample bank between io_ctrl and a 4-point FFT core: fill, compute, drain.
// Optional feature: define SAMPLE_BANK_OVERRUN_EN to add the sticky overrun_o flag.
module fft_sample_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic             load_pulse_i,
    input  logic             output_pulse_i,
    input  logic [1:0]       addr_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             fft_done_i,
    input  logic [WIDTH-1:0] r0_i,
    input  logic [WIDTH-1:0] r1_i,
    input  logic [WIDTH-1:0] r2_i,
    input  logic [WIDTH-1:0] r3_i,
    output logic [WIDTH-1:0] s0_o,
    output logic [WIDTH-1:0] s1_o,
    output logic [WIDTH-1:0] s2_o,
    output logic [WIDTH-1:0] s3_o,
    output logic             fft_start_o,
    output logic [WIDTH-1:0] data_out_o,
`ifdef SAMPLE_BANK_OVERRUN_EN
    output logic             overrun_o,
`endif
    output logic             busy_o
);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] samp_q [4];
    logic [WIDTH-1:0] samp_d [4];
    logic [WIDTH-1:0] res_q  [4];
    logic [WIDTH-1:0] res_d  [4];
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       read_q, read_d;
    logic [3:0]       addr_oh_s;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             fft_start_q, fft_start_d;
    logic             busy_q, busy_d;
`ifdef SAMPLE_BANK_OVERRUN_EN
    logic             overrun_q, overrun_d;
`endif

    assign addr_oh_s = 4'b0001 << addr_i;

    // Next-state logic: every update is gated by ena_i; fft_start is a self-clearing pulse.
    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        res_d       = res_q;
        valid_d     = valid_q;
        read_d      = read_q;
        data_out_d  = data_out_q;
        busy_d      = busy_q;
        fft_start_d = 1'b0;
`ifdef SAMPLE_BANK_OVERRUN_EN
        overrun_d   = overrun_q;
        if (ena_i && load_pulse_i && (state_q != ST_FILL)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
`endif
        if (ena_i) begin
            case (state_q)
                ST_FILL: begin
                    // Load has priority over a simultaneous output request while filling.
                    if (load_pulse_i) begin
                        samp_d[addr_i] = data_in_i;
                        valid_d        = valid_q | addr_oh_s;
                        if ((valid_q | addr_oh_s) == 4'b1111) begin
                            state_d     = ST_COMPUTE;
                            fft_start_d = 1'b1;
                            busy_d      = 1'b1;
                        end else begin
                            state_d     = ST_FILL;
                        end
                    end else if (output_pulse_i) begin
                        data_out_d = res_q[addr_i];
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_COMPUTE: begin
                    if (fft_done_i) begin
                        res_d[0] = r0_i;
                        res_d[1] = r1_i;
                        res_d[2] = r2_i;
                        res_d[3] = r3_i;
                        busy_d   = 1'b0;
                        state_d  = ST_DRAIN;
                    end else begin
                        state_d  = ST_COMPUTE;
                    end
                end
                ST_DRAIN: begin
                    if (output_pulse_i) begin
                        data_out_d = res_q[addr_i];
                        if ((read_q | addr_oh_s) == 4'b1111) begin
                            read_d  = 4'b0000;
                            valid_d = 4'b0000;
                            state_d = ST_FILL;
                        end else begin
                            read_d  = read_q | addr_oh_s;
                        end
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_FILL;
            for (int i = 0; i < 4; i++) begin
                samp_q[i] <= {WIDTH{1'b0}};
                res_q[i]  <= {WIDTH{1'b0}};
            end
            valid_q     <= 4'b0000;
            read_q      <= 4'b0000;
            data_out_q  <= {WIDTH{1'b0}};
            fft_start_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SAMPLE_BANK_OVERRUN_EN
            overrun_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            res_q       <= res_d;
            valid_q     <= valid_d;
            read_q      <= read_d;
            data_out_q  <= data_out_d;
            fft_start_q <= fft_start_d;
            busy_q      <= busy_d;
`ifdef SAMPLE_BANK_OVERRUN_EN
            overrun_q   <= overrun_d;
`endif
        end
    end

    assign s0_o        = samp_q[0];
    assign s1_o        = samp_q[1];
    assign s2_o        = samp_q[2];
    assign s3_o        = samp_q[3];
    // The start pulse must never reach the core while the design is disabled.
    assign fft_start_o = fft_start_q & ena_i;
    assign data_out_o  = data_out_q;
    assign busy_o      = busy_q;
`ifdef SAMPLE_BANK_OVERRUN_EN
    assign overrun_o   = overrun_q;
`endif

endmodule
